// File: rtl/hft_uart_pkg.sv
// hft_uart_pkg
// Shared types and helpers for the market-data UART front end.
//   uart_rx_state_e : receiver FSM states
//   UART_DATA_BITS  : data bits per character
//   clks_per_bit()  : clock cycles per serial bit (truncating divide)
//   parity_bad()    : even-parity check over data plus received parity bit
package hft_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } uart_rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Even parity: data plus parity bit must hold an even number of ones.
  function automatic logic parity_bad(input logic [UART_DATA_BITS-1:0] data,
                                      input logic                      par_bit);
    return ^{data, par_bit};
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_sync.sv
// rx_bit_sync
// Two-flop synchroniser for asynchronous inputs. Both stages reset to all ones
// so an idle-high serial line reads as idle straight out of reset.
// Ports:
//   clk    in        system clock
//   rst_n  in        asynchronous active-low reset
//   d      in  WIDTH asynchronous input
//   q      out WIDTH synchronised output
module rx_bit_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability filter: two back-to-back capture stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Recovers UART characters from the asynchronous serial pin and presents each
// good byte as a one-cycle strobe to the packet framer. Every decision is taken
// on the synchronised line, sampling at bit centres.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with a parity_err
// strobe; without it the frame is 8N1 and parity_err does not exist.
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   uart_rx    in   1  serial line, idle high, LSB first
//   rx_byte    out  8  last good byte, held until the next good byte
//   rx_valid   out  1  one-cycle strobe, rx_byte is new
//   frame_err  out  1  one-cycle strobe, stop bit sampled low
//   busy       out  1  high whenever the receiver is not in IDLE
//   parity_err out  1  one-cycle strobe, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_deserializer
  import hft_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_e              state_r,     state_nxt_s;
  logic [CNT_W-1:0]            cnt_r,       cnt_nxt_s;
  logic [2:0]                  bit_idx_r,   bit_idx_nxt_s;
  logic [UART_DATA_BITS-1:0]   shreg_r,     shreg_nxt_s;
  logic [UART_DATA_BITS-1:0]   rx_byte_r,   rx_byte_nxt_s;
  logic                        rx_valid_r,  rx_valid_nxt_s;
  logic                        frame_err_r, frame_err_nxt_s;
  logic                        busy_r;
  // Fills with ones over the two cycles after reset; until then rx_s still
  // shows the synchroniser's reset value rather than the real line.
  logic [1:0]                  primed_r;
`ifdef UART_RX_PARITY_EN
  logic                        parity_r,     parity_nxt_s;
  logic                        parity_err_r, parity_err_nxt_s;
`endif

  rx_bit_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rx_s)
  );

  // Next-state, bit timing, shifting and strobe decode.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = CNT_ZERO;
    bit_idx_nxt_s   = bit_idx_r;
    shreg_nxt_s     = shreg_r;
    rx_byte_nxt_s   = rx_byte_r;
    rx_valid_nxt_s  = 1'b0;
    frame_err_nxt_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_nxt_s     = parity_r;
    parity_err_nxt_s = 1'b0;
`endif
    case (state_r)
      WAIT_HIGH: begin
        // A stale synchroniser value must not end the wait after reset.
        if (rx_s && (primed_r == 2'b11)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_HIGH;
        end
      end
      IDLE: begin
        if (!rx_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          if (!rx_s) begin
            state_nxt_s   = DATA;
            bit_idx_nxt_s = 3'd0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          shreg_nxt_s = {rx_s, shreg_r[UART_DATA_BITS-1:1]};
          if (bit_idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
            bit_idx_nxt_s = 3'd0;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == BIT_LAST) begin
          parity_nxt_s = rx_s;
          state_nxt_s  = STOP;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          if (rx_s) begin
            // Back to IDLE mid stop bit so a directly following start edge is seen.
            state_nxt_s = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad(shreg_r, parity_r)) begin
              parity_err_nxt_s = 1'b1;
            end else begin
              rx_valid_nxt_s = 1'b1;
              rx_byte_nxt_s  = shreg_r;
            end
`else
            rx_valid_nxt_s = 1'b1;
            rx_byte_nxt_s  = shreg_r;
`endif
          end else begin
            // Low stop bit: a held-low break must not retrigger, so wait for high.
            frame_err_nxt_s = 1'b1;
            state_nxt_s     = WAIT_HIGH;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = WAIT_HIGH;
      end
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= WAIT_HIGH;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shreg_r     <= {UART_DATA_BITS{1'b0}};
      rx_byte_r   <= {UART_DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b1;
      primed_r    <= 2'b00;
`ifdef UART_RX_PARITY_EN
      parity_r     <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      shreg_r     <= shreg_nxt_s;
      rx_byte_r   <= rx_byte_nxt_s;
      rx_valid_r  <= rx_valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      primed_r    <= {primed_r[0], 1'b1};
`ifdef UART_RX_PARITY_EN
      parity_r     <= parity_nxt_s;
      parity_err_r <= parity_err_nxt_s;
`endif
    end
  end

  assign rx_byte   = rx_byte_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule
